wb_regfile_scoreboard: RTL and testbench

//  Consumer end of the MEM/WB pipeline interface: selects write-back data, commits it to an
//  8 x 16-bit register file and serves two decode-stage read ports with same-cycle write bypass.
//  Per-register pending-write counters (scoreboard) raise a decode stall when an issuing

---
 rtl/wb_regfile_scoreboard_pkg.sv | 18 +
 rtl/wb_pend_counter.sv | 44 ++++
 rtl/wb_regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_wb_regfile_scoreboard.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared definitions for the MEM/WB -> ID boundary: widths, register-address
// and data typedefs, and pending-counter limits used by the register file
// scoreboard and by the neighbouring pipeline stages.
package wb_regfile_scoreboard_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int PEND_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PEND_W-1:0] pend_cnt_t;

  localparam reg_addr_t REG_ZERO = '0;
  localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/wb_pend_counter.sv
// Pending-write counter for one architectural register.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   inc_i          an instruction writing this register issued this cycle
//   dec_i          a write-back to this register lands this cycle
//   cnt_o          registered pending count
//   cnt_next_o     count that will be loaded at the next edge
// Simultaneous inc and dec cancel out. The count never wraps in either
// direction: a decrement at zero or an increment at the maximum holds.
module wb_pend_counter
  import wb_regfile_scoreboard_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      inc_i,
  input  logic      dec_i,
  output pend_cnt_t cnt_o,
  output pend_cnt_t cnt_next_o
);

  pend_cnt_t cnt_q;
  pend_cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != PEND_MAX)) begin
      cnt_d = cnt_q + pend_cnt_t'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - pend_cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back consumer: selects write-back data, commits it to an 8 x 16-bit
// register file (r0 hardwired to zero), serves two decode read ports with
// write-first bypass, and tracks in-flight writes per register to stall
// decode on read-after-write hazards or counter exhaustion.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   wb_memtoreg/readdata/aluresult   write-back data select and sources
//   wb_writereg, wb_regwrite         write-back destination and enable
//   rd_addr_a/b -> rd_data_a/b       combinational decode reads
//   iss_valid/regwrite/dest          instruction issue from decode
//   wb_data                          selected write-back value
//   stall                            decode must hold; issue not accepted
//   pend_any                         registered: any write still in flight
// Handshake: an issue is accepted in a cycle exactly when iss_valid=1 and
// stall=0; stall depends combinationally on this cycle's inputs, so decode
// simply holds its instruction while stall is high.
module wb_regfile_scoreboard
  import wb_regfile_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_memtoreg,
  input  data_t     wb_readdata,
  input  data_t     wb_aluresult,
  input  reg_addr_t wb_writereg,
  input  logic      wb_regwrite,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  logic      iss_valid,
  input  logic      iss_regwrite,
  input  reg_addr_t iss_dest,
  output data_t     rd_data_a,
  output data_t     rd_data_b,
  output data_t     wb_data,
  output logic      stall,
  output logic      pend_any
);

  data_t regs_q [NUM_REGS];
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt;
  logic [NUM_REGS-1:0][PEND_W-1:0] cnt_next;
  logic [NUM_REGS-1:0] w_vec;
  logic [NUM_REGS-1:0] i_vec;
  logic pend_any_q;
  logic pend_a, pend_b, dest_full;

  assign wb_data = wb_memtoreg ? wb_readdata : wb_aluresult;

  // Per-register write-back and accepted-issue events; r0 never has either.
  always_comb begin
    w_vec = '0;
    i_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_vec[r] = wb_regwrite && (wb_writereg == reg_addr_t'(r));
      i_vec[r] = iss_valid && !stall && iss_regwrite && (iss_dest == reg_addr_t'(r));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wb_regwrite && (wb_writereg != REG_ZERO)) begin
      regs_q[wb_writereg] <= wb_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != REG_ZERO) begin
      rd_data_a = w_vec[rd_addr_a] ? wb_data : regs_q[rd_addr_a];
    end
    rd_data_b = '0;
    if (rd_addr_b != REG_ZERO) begin
      rd_data_b = w_vec[rd_addr_b] ? wb_data : regs_q[rd_addr_b];
    end
  end

  // A write-back landing this cycle is covered by the bypass, so it removes
  // one pending write from the hazard view before the counter catches up.
  always_comb begin
    pend_a = (rd_addr_a != REG_ZERO) &&
             (cnt[rd_addr_a] > (w_vec[rd_addr_a] ? pend_cnt_t'(1) : pend_cnt_t'(0)));
    pend_b = (rd_addr_b != REG_ZERO) &&
             (cnt[rd_addr_b] > (w_vec[rd_addr_b] ? pend_cnt_t'(1) : pend_cnt_t'(0)));
    dest_full = iss_regwrite && (iss_dest != REG_ZERO) &&
                (cnt[iss_dest] == PEND_MAX) && !w_vec[iss_dest];
    stall = iss_valid && (pend_a || pend_b || dest_full);
  end

  assign cnt[0]      = '0;
  assign cnt_next[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
    wb_pend_counter u_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .inc_i      (i_vec[g]),
      .dec_i      (w_vec[g]),
      .cnt_o      (cnt[g]),
      .cnt_next_o (cnt_next[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_any_q <= 1'b0;
    end else begin
      pend_any_q <= |cnt_next;
    end
  end

  assign pend_any = pend_any_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
module tb_wb_regfile_scoreboard;
  import wb_regfile_scoreboard_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      wb_memtoreg;
  data_t     wb_readdata;
  data_t     wb_aluresult;
  reg_addr_t wb_writereg;
  logic      wb_regwrite;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  logic      iss_valid;
  logic      iss_regwrite;
  reg_addr_t iss_dest;
  data_t     rd_data_a;
  data_t     rd_data_b;
  data_t     wb_data;
  logic      stall;
  logic      pend_any;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  wb_regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .wb_memtoreg  (wb_memtoreg),
    .wb_readdata  (wb_readdata),
    .wb_aluresult (wb_aluresult),
    .wb_writereg  (wb_writereg),
    .wb_regwrite  (wb_regwrite),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .iss_valid    (iss_valid),
    .iss_regwrite (iss_regwrite),
    .iss_dest     (iss_dest),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wb_data      (wb_data),
    .stall        (stall),
    .pend_any     (pend_any)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wb_memtoreg  = 1'b0;
    wb_readdata  = '0;
    wb_aluresult = '0;
    wb_writereg  = '0;
    wb_regwrite  = 1'b0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    iss_valid    = 1'b0;
    iss_regwrite = 1'b0;
    iss_dest     = '0;
  endtask

  task automatic drive_wb(input logic mem, input data_t rdata, input data_t alu,
                          input reg_addr_t dst);
    wb_regwrite  = 1'b1;
    wb_memtoreg  = mem;
    wb_readdata  = rdata;
    wb_aluresult = alu;
    wb_writereg  = dst;
  endtask

  task automatic drive_iss(input logic rw, input reg_addr_t dst);
    iss_valid    = 1'b1;
    iss_regwrite = rw;
    iss_dest     = dst;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard compare: expected read data was queued when the write was driven.
  task automatic chk_q(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    data_t rnd;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    rd_addr_a = 3'd5;
    drive_iss(1'b0, 3'd0);
    settle();
    chk("reset_pend_any", {15'd0, pend_any}, 16'd0);
    chk("reset_stall", {15'd0, stall}, 16'd0);
    chk("reset_rd_a5", rd_data_a, 16'h0000);
    idle();

    // Write with same-cycle bypass, then stored value
    drive_wb(1'b0, 16'hDEAD, 16'h1234, 3'd2);
    rd_addr_a = 3'd2;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    settle();
    chk("wb_data_alu", wb_data, 16'h1234);
    chk_q("bypass_rd_a2", rd_data_a);
    tick();
    wb_regwrite = 1'b0;
    settle();
    chk_q("stored_rd_a2", rd_data_a);
    chk("no_underflow_cnt2", {14'd0, dut.cnt[2]}, 16'd0);

    // Mux select and r0
    drive_wb(1'b1, 16'hBEEF, 16'h5555, 3'd0);
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd2;
    settle();
    chk("wb_data_mem", wb_data, 16'hBEEF);
    chk("r0_bypass_zero", rd_data_a, 16'h0000);
    tick();
    wb_regwrite = 1'b0;
    settle();
    chk("r0_stored_zero", rd_data_a, 16'h0000);
    chk("r2_untouched", rd_data_b, 16'h1234);
    chk("r0_write_pend_any", {15'd0, pend_any}, 16'd0);
    idle();

    // RAW hazard on r4
    drive_iss(1'b1, 3'd4);
    settle();
    chk("iss4_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("cnt4_after_issue", {14'd0, dut.cnt[4]}, 16'd1);
    chk("pend_any_after_issue", {15'd0, pend_any}, 16'd1);
    drive_iss(1'b0, 3'd0);
    rd_addr_b = 3'd4;
    settle();
    chk("raw_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("raw_stall_hold", {15'd0, stall}, 16'd1);
    rnd = data_t'($urandom_range(1, 16'hFFFF));
    drive_wb(1'b0, 16'h0000, rnd, 3'd4);
    exp_q.push_back(rnd);
    exp_q.push_back(rnd);
    settle();
    chk("raw_release_stall", {15'd0, stall}, 16'd0);
    chk_q("raw_bypass_rd_b4", rd_data_b);
    tick();
    idle();
    rd_addr_b = 3'd4;
    settle();
    chk("cnt4_after_wb", {14'd0, dut.cnt[4]}, 16'd0);
    chk("pend_any_cleared", {15'd0, pend_any}, 16'd0);
    chk_q("r4_stored", rd_data_b);
    idle();

    // Simultaneous issue and write-back on r6
    drive_iss(1'b1, 3'd6);
    tick();
    drive_wb(1'b0, 16'h0000, 16'h6666, 3'd6);
    rd_addr_a = 3'd6;
    exp_q.push_back(16'h6666);
    settle();
    chk("simul_stall", {15'd0, stall}, 16'd0);
    chk_q("simul_bypass_rd_a6", rd_data_a);
    tick();
    chk("simul_cnt6", {14'd0, dut.cnt[6]}, 16'd1);
    idle();
    drive_wb(1'b0, 16'h0000, 16'h0606, 3'd6);
    tick();
    idle();
    settle();
    chk("cnt6_drained", {14'd0, dut.cnt[6]}, 16'd0);

    // Saturation on r1
    for (int k = 0; k < 3; k++) begin
      drive_iss(1'b1, 3'd1);
      settle();
      chk("sat_issue_stall", {15'd0, stall}, 16'd0);
      tick();
    end
    chk("sat_cnt1_max", {14'd0, dut.cnt[1]}, 16'd3);
    drive_iss(1'b1, 3'd1);
    settle();
    chk("sat_full_stall", {15'd0, stall}, 16'd1);
    tick();
    chk("sat_cnt1_held", {14'd0, dut.cnt[1]}, 16'd3);
    idle();
    drive_wb(1'b0, 16'h0000, 16'h0101, 3'd1);
    tick();
    idle();
    settle();
    chk("sat_cnt1_dec", {14'd0, dut.cnt[1]}, 16'd2);
    chk("sat_pend_any", {15'd0, pend_any}, 16'd1);

    // Reset mid-run with r3 holding two pending writes
    drive_iss(1'b1, 3'd3);
    tick();
    tick();
    idle();
    settle();
    chk("pre_reset_cnt3", {14'd0, dut.cnt[3]}, 16'd2);
    #2;
    rst = 1'b1;
    settle();
    drive_iss(1'b0, 3'd0);
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd3;
    settle();
    chk("rst_cnt3", {14'd0, dut.cnt[3]}, 16'd0);
    chk("rst_cnt1", {14'd0, dut.cnt[1]}, 16'd0);
    chk("rst_pend_any", {15'd0, pend_any}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_rd_a5", rd_data_a, 16'h0000);
    rd_addr_b = 3'd2;
    settle();
    chk("rst_regs_cleared", rd_data_b, 16'h0000);
    tick();
    rst = 1'b0;
    idle();
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
